alu_issue: RTL
==============

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: NREGS, default 4, number of internal 8-bit registers (address width clog2(NREGS), fixed 2 at default).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 instr_valid  input  1  instruction word present.
REQ-005 instr_ready  output  1  block can accept instruction.
REQ-006 instr  input  9  [8:6] op, [5:4] rd, [3:2] rs, [1:0] rt.
REQ-007 alu_op  output  3  opcode driven to ALU: 000 ADD, 001 SUB, 010 AND, 011 XOR.
REQ-008 alu_in1 / alu_in2  output  8 each  operands, reg[rs] / reg[rt].
REQ-009 alu_out  input  8  ALU result, combinational from alu_op/alu_in1/alu_in2.
REQ-010 alu_zero  input  1  ALU zero indication.
REQ-011 wr_en, wr_addr, wr_data  input  1/2/8  host register preload.
REQ-012 rd_addr  input  2; rd_data  output  8  combinational host register read.
REQ-013 done  output  1  one-cycle pulse on writeback.
REQ-014 zero_flag  output  1  registered alu_zero of last completed instruction.
REQ-015 err  output  1  one-cycle pulse on illegal opcode (op[2]=1).

Function
REQ-016 FSM states IDLE, ISSUE, WB; instr_ready=1 in IDLE only (see REQ-030).
REQ-017 Accept on instr_valid&&instr_ready; latch op/rd/rs/rt into instruction register.
REQ-018 IDLE, accept, legal op -> ISSUE; accept, illegal op -> IDLE with err=1 next cycle, no register or flag change.
REQ-019 ISSUE: drive alu_op/alu_in1/alu_in2 from latched fields; capture alu_out and alu_zero at end of cycle; -> WB.
REQ-020 WB: write captured result to reg[rd], update zero_flag, done=1 for this cycle; -> IDLE.
REQ-021 Outside ISSUE, alu_op=000 and alu_in1=alu_in2=0.
REQ-022 Latency: accept edge to done asserted = 2 cycles; throughput 1 instruction / 3 cycles.
REQ-023 Arithmetic modulo 2^8 (wrap, no carry/borrow output); rs=rt allowed; rd may equal rs/rt.
REQ-024 Host write in any state; same cycle as WB writeback to same address: writeback wins, host write dropped; different addresses: both write.
REQ-025 Host write to reg[rs]/reg[rt] during ISSUE takes effect on the next instruction only; operands are read from the register file during ISSUE (write lands at edge ending ISSUE).
REQ-026 rd_data reflects register contents after last edge (no write-through).
REQ-027 instr held while instr_valid=1 and instr_ready=0 is not consumed.

Reset
REQ-028 rst_n=0 asynchronously: state IDLE, all registers 0, instruction register 0, zero_flag=0, done=0, err=0; instr_ready=1 after release.
REQ-029 Reset mid-instruction aborts it: no writeback, no done.

Configuration
REQ-030 Macro ALU_ISSUE_PIPE_EN defined: instr_ready=1 in IDLE and WB; accept in WB -> ISSUE directly (or -> IDLE + err if illegal) concurrent with current writeback; throughput 1 / 2 cycles. Undefined: behaviour per REQ-016..REQ-022.
REQ-031 With ALU_ISSUE_PIPE_EN, an instruction accepted in WB reading the WB rd sees the new value (write completes at edge ending WB).

Structure
REQ-032 Package alu_pkg: opcode enum (ADD, SUB, AND, XOR), instruction field widths/positions, FSM state enum.
REQ-033 Sub-module alu_issue_regfile: NREGS x 8, two combinational operand read ports, one debug read port, two write ports with REQ-024 priority.
REQ-034 ALU instantiated outside alu_issue; bench connects an ALU model.

Verification
REQ-035 Preload r1=0x05, r2=0x03; instr ADD rd=0 rs=1 rt=2 -> done 2 cycles after accept, r0=0x08, zero_flag=0.
REQ-036 r1=0x03, r2=0x05, SUB rd=3 -> r3=0xFE; then XOR rd=3 rs=3 rt=3 -> r3=0x00, zero_flag=1.
REQ-037 instr op=101 -> err pulse one cycle after accept, no done, all registers unchanged, instr_ready=1 next cycle.
REQ-038 Host wr_en to rd=0 with 0xAA in WB cycle of ADD writing r0=0x08 -> r0=0x08; host write to r2 same cycle -> r2=0xAA.
REQ-039 rst_n low during ISSUE of ADD rd=0 -> r0=0, done never asserts, zero_flag=0.
REQ-040 With ALU_ISSUE_PIPE_EN, instr_valid held high with 4 ADDs -> done every 2nd cycle, chained result correct; without macro -> done every 3rd cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue block: opcodes, instruction word layout and
// FSM state encodings.
package alu_pkg;

    localparam int DATA_W  = 8;
    localparam int OP_W    = 3;
    localparam int FIELD_W = 2;
    localparam int INSTR_W = OP_W + 3 * FIELD_W;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WB    = 2'b10
    } state_e;

    // Field order matches the instruction word: [8:6] op, [5:4] rd, [3:2] rs, [1:0] rt.
    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic [FIELD_W-1:0] rd;
        logic [FIELD_W-1:0] rs;
        logic [FIELD_W-1:0] rt;
    } instr_t;

    function automatic logic op_illegal(input logic [OP_W-1:0] op);
        return op[OP_W-1];
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Instruction handshake plus the operand/result bus to the external ALU.
// slave = the issue block, master = whoever feeds instructions and hosts the ALU.
interface alu_issue_if;
    import alu_pkg::*;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [OP_W-1:0]    alu_op;
    logic [DATA_W-1:0]  alu_in1;
    logic [DATA_W-1:0]  alu_in2;
    logic [DATA_W-1:0]  alu_out;
    logic               alu_zero;

    modport master (
        output instr_valid, instr, alu_out, alu_zero,
        input  instr_ready, alu_op, alu_in1, alu_in2
    );

    modport slave (
        input  instr_valid, instr, alu_out, alu_zero,
        output instr_ready, alu_op, alu_in1, alu_in2
    );

endinterface

// File: rtl/alu_issue_regfile.sv
// NREGS x 8 register file: two operand read ports, one debug read port,
// writeback port that overrides a same-address host write.
module alu_issue_regfile
    import alu_pkg::*;
#(
    parameter int NREGS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [$clog2(NREGS)-1:0]   rs_addr,
    input  logic [$clog2(NREGS)-1:0]   rt_addr,
    output logic [DATA_W-1:0]          rs_data,
    output logic [DATA_W-1:0]          rt_data,
    input  logic [$clog2(NREGS)-1:0]   dbg_addr,
    output logic [DATA_W-1:0]          dbg_data,
    input  logic                       wb_en,
    input  logic [$clog2(NREGS)-1:0]   wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       host_en,
    input  logic [$clog2(NREGS)-1:0]   host_addr,
    input  logic [DATA_W-1:0]          host_data
);

    localparam int AW = $clog2(NREGS);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    assign rs_data  = regs_q[rs_addr];
    assign rt_data  = regs_q[rt_addr];
    assign dbg_data = regs_q[dbg_addr];

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NREGS; i++) begin
            if (wb_en && (wb_addr == AW'(i))) begin
                regs_d[i] = wb_data;
            end else if (host_en && (host_addr == AW'(i))) begin
                regs_d[i] = host_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Three-state issue/writeback sequencer driving an external combinational ALU.
// Build option: ALU_ISSUE_PIPE_EN also accepts in WB, overlapping issue with writeback.
module alu_issue
    import alu_pkg::*;
#(
    parameter int NREGS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    alu_issue_if.slave                bus,
    input  logic                      wr_en,
    input  logic [$clog2(NREGS)-1:0]  wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic [$clog2(NREGS)-1:0]  rd_addr,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      done,
    output logic                      zero_flag,
    output logic                      err
);

    localparam int AW = $clog2(NREGS);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] ISSUE = ST_ISSUE;
    localparam logic [1:0] WB    = ST_WB;

    logic [1:0]        state_q, state_d;
    instr_t            ir_q, ir_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              zres_q, zres_d;
    logic              zero_flag_q, zero_flag_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              ready;
    logic              accept;
    instr_t            new_ir;
    logic [DATA_W-1:0] rs_data, rt_data;

`ifdef ALU_ISSUE_PIPE_EN
    assign ready = (state_q == IDLE) || (state_q == WB);
`else
    assign ready = (state_q == IDLE);
`endif

    assign new_ir          = bus.instr;
    assign accept          = bus.instr_valid && ready;
    assign bus.instr_ready = ready;

    // ALU bus is quiet outside ISSUE so the external ALU sees a stable ADD 0,0.
    always_comb begin
        bus.alu_op  = '0;
        bus.alu_in1 = '0;
        bus.alu_in2 = '0;
        if (state_q == ISSUE) begin
            bus.alu_op  = ir_q.op;
            bus.alu_in1 = rs_data;
            bus.alu_in2 = rt_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        res_d       = res_q;
        zres_d      = zres_q;
        zero_flag_d = zero_flag_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ISSUE: begin
                res_d   = bus.alu_out;
                zres_d  = bus.alu_zero;
                done_d  = 1'b1;
                state_d = WB;
            end
            WB: begin
                zero_flag_d = zres_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // In pipelined builds an accept in WB overrides the return to IDLE.
        if (accept) begin
            ir_d = new_ir;
            if (op_illegal(new_ir.op)) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                state_d = ISSUE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ir_q        <= '0;
            res_q       <= '0;
            zres_q      <= 1'b0;
            zero_flag_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            res_q       <= res_d;
            zres_q      <= zres_d;
            zero_flag_q <= zero_flag_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign done      = done_q;
    assign err       = err_q;
    assign zero_flag = zero_flag_q;

    alu_issue_regfile #(
        .NREGS (NREGS)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs_addr   (AW'(ir_q.rs)),
        .rt_addr   (AW'(ir_q.rt)),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .dbg_addr  (rd_addr),
        .dbg_data  (rd_data),
        .wb_en     (state_q == WB),
        .wb_addr   (AW'(ir_q.rd)),
        .wb_data   (res_q),
        .host_en   (wr_en),
        .host_addr (wr_addr),
        .host_data (wr_data)
    );

endmodule
